// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between predictor/execution side and the branch resolve queue.
// master drives predictions and resolves; slave is the queue itself.
interface branch_resolve_queue_if;
  logic pred_valid;
  logic pred_bit;
  logic pred_ready;
  logic resolve_valid;
  logic resolve_taken;
  logic upd_result;
  logic upd_taken;
  logic mispredict;

  modport master (
    output pred_valid, pred_bit, resolve_valid, resolve_taken,
    input  pred_ready, upd_result, upd_taken, mispredict
  );

  modport slave (
    input  pred_valid, pred_bit, resolve_valid, resolve_taken,
    output pred_ready, upd_result, upd_taken, mispredict
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued branch predictions, paired with resolved outcomes to
// generate predictor update pulses, mispredict flushes and saturating statistics.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  branch_resolve_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           resolve_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic                       err_underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] resolve_cnt_q, resolve_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             err_q, err_d;
  logic             upd_result_q, upd_result_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;

  logic empty, ready, push, pop, head, miss;

  always_comb begin
    empty = (occ_q == '0);
    ready = (occ_q != (AW+1)'(DEPTH));
    push  = bus.pred_valid && ready;
    pop   = bus.resolve_valid && !empty;
    head  = mem_q[rd_ptr_q];
    miss  = pop && (head != bus.resolve_taken);

    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    resolve_cnt_d = resolve_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    err_d         = err_q | (bus.resolve_valid && empty);
    upd_result_d  = pop;
    upd_taken_d   = pop && bus.resolve_taken;
    mispredict_d  = miss;

    // A mispredict makes every younger entry (and any same-cycle push) wrong-path.
    if (miss) begin
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.pred_bit;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    if (pop && (resolve_cnt_q != '1)) resolve_cnt_d = resolve_cnt_q + CNT_W'(1);
    if (miss && (miss_cnt_q != '1))   miss_cnt_d    = miss_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      resolve_cnt_q <= '0;
      miss_cnt_q    <= '0;
      err_q         <= 1'b0;
      upd_result_q  <= 1'b0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      resolve_cnt_q <= resolve_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      err_q         <= err_d;
      upd_result_q  <= upd_result_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
    end
  end

  assign bus.pred_ready = ready;
  assign bus.upd_result = upd_result_q;
  assign bus.upd_taken  = upd_taken_q;
  assign bus.mispredict = mispredict_q;
  assign occupancy      = occ_q;
  assign resolve_cnt    = resolve_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign err_underflow  = err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, queue-based reference
// model under random traffic, and a narrow-counter instance for saturation.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_queue_if bus ();
  branch_resolve_queue_if sbus ();
  logic [$clog2(DEPTH):0] occupancy, s_occupancy;
  logic [CNT_W-1:0]       resolve_cnt, miss_cnt;
  logic [SAT_W-1:0]       s_resolve_cnt, s_miss_cnt;
  logic                   err_underflow, s_err_underflow;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .occupancy(occupancy),
    .resolve_cnt(resolve_cnt), .miss_cnt(miss_cnt), .err_underflow(err_underflow)
  );

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave), .occupancy(s_occupancy),
    .resolve_cnt(s_resolve_cnt), .miss_cnt(s_miss_cnt), .err_underflow(s_err_underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of predicted bits plus counts.
  bit      mq[$];
  longint  m_res, m_miss;
  bit      m_err, e_upd, e_tk, e_ms;
  longint  sat_max = (longint'(1) << CNT_W) - 1;

  task automatic model_clear();
    mq.delete();
    m_res = 0; m_miss = 0; m_err = 0; e_upd = 0; e_tk = 0; e_ms = 0;
  endtask

  task automatic model_step(input bit pv, input bit pb, input bit rv, input bit rt);
    bit can_take, h;
    can_take = (mq.size() < DEPTH);
    e_upd = 0; e_tk = 0; e_ms = 0;
    if (rv) begin
      if (mq.size() == 0) m_err = 1;
      else begin
        h = mq.pop_front();
        e_upd = 1; e_tk = rt; e_ms = (h != rt);
        if (m_res < sat_max) m_res++;
        if (e_ms && m_miss < sat_max) m_miss++;
      end
    end
    if (e_ms) mq.delete();
    else if (pv && can_take) mq.push_back(pb);
  endtask

  // One cycle on the main DUT; inputs driven #1 after an edge, outputs sampled #1 after the next.
  task automatic apply(input bit pv, input bit pb, input bit rv, input bit rt, output bit rdy_seen);
    bus.pred_valid = pv; bus.pred_bit = pb; bus.resolve_valid = rv; bus.resolve_taken = rt;
    #1;
    rdy_seen = bus.pred_ready;
    chk("model_pred_ready", bus.pred_ready, mq.size() < DEPTH);
    @(posedge clk); #1;
    model_step(pv, pb, rv, rt);
    chk("model_upd_result", bus.upd_result, e_upd);
    chk("model_upd_taken", bus.upd_taken, e_tk);
    chk("model_mispredict", bus.mispredict, e_ms);
    chk("model_occupancy", occupancy, mq.size());
    chk("model_resolve_cnt", resolve_cnt, m_res);
    chk("model_miss_cnt", miss_cnt, m_miss);
    chk("model_err_underflow", err_underflow, m_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pred_valid = 1'b1; bus.pred_bit = 1'($urandom_range(0, 1));
    bus.resolve_valid = 1'b1; bus.resolve_taken = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_pred_ready", bus.pred_ready, 1);
    chk("rst_upd_result", bus.upd_result, 0);
    chk("rst_upd_taken", bus.upd_taken, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    chk("rst_resolve_cnt", resolve_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_err_underflow", err_underflow, 0);
    rst_n = 1'b1;
    bus.pred_valid = 1'b0; bus.resolve_valid = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit pv, pb, rv, rt;
    bit ready, upd, tk, ms;
    int occ;
    bit err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit pv, bit pb, bit rv, bit rt,
                              bit ready, bit upd, bit tk, bit ms, int occ, bit err);
    vec_t v;
    v.pv = pv; v.pb = pb; v.rv = rv; v.rt = rt;
    v.ready = ready; v.upd = upd; v.tk = tk; v.ms = ms; v.occ = occ; v.err = err;
    tbl.push_back(v);
  endfunction

  initial begin
    bit rdy;
    sbus.pred_valid = 0; sbus.pred_bit = 0; sbus.resolve_valid = 0; sbus.resolve_taken = 0;
    model_clear();

    //   pv pb rv rt | ready upd tk ms occ err
    // correct stream 1,1,0
    add(1, 1, 0, 0,   1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0,   1, 0, 0, 0, 2, 0);
    add(1, 0, 0, 0,   1, 0, 0, 0, 3, 0);
    add(0, 0, 1, 1,   1, 1, 1, 0, 2, 0);
    add(0, 0, 1, 1,   1, 1, 1, 0, 1, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    // fill with 1s, drop a push while full, then mispredict with a push alongside
    add(1, 1, 0, 0,   1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0,   1, 0, 0, 0, 2, 0);
    add(1, 1, 0, 0,   1, 0, 0, 0, 3, 0);
    add(1, 1, 0, 0,   1, 0, 0, 0, 4, 0);
    add(1, 0, 0, 0,   0, 0, 0, 0, 4, 0);
    add(1, 0, 1, 0,   0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    // fill with 0s, pop+push while full: push dropped, remaining three drain cleanly
    add(1, 0, 0, 0,   1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0,   1, 0, 0, 0, 2, 0);
    add(1, 0, 0, 0,   1, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0,   1, 0, 0, 0, 4, 0);
    add(1, 1, 1, 0,   0, 1, 0, 0, 3, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0, 2, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 0);
    // underflow with same-cycle push: no bypass, entry kept
    add(1, 1, 1, 0,   1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 1,   1, 1, 1, 0, 0, 1);
    // mispredict with non-full push alongside
    add(1, 1, 0, 0,   1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0,   1, 1, 0, 1, 0, 1);
    // non-full push+pop without mispredict
    add(1, 1, 0, 0,   1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 1,   1, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0,   1, 1, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].pv, tbl[i].pb, tbl[i].rv, tbl[i].rt, rdy);
      chk($sformatf("vec%0d_pred_ready", i), rdy, tbl[i].ready);
      chk($sformatf("vec%0d_upd_result", i), bus.upd_result, tbl[i].upd);
      chk($sformatf("vec%0d_upd_taken", i), bus.upd_taken, tbl[i].tk);
      chk($sformatf("vec%0d_mispredict", i), bus.mispredict, tbl[i].ms);
      chk($sformatf("vec%0d_occupancy", i), occupancy, tbl[i].occ);
      chk($sformatf("vec%0d_err_underflow", i), err_underflow, tbl[i].err);
      if (i == 6) begin
        chk("stream_resolve_cnt", resolve_cnt, 3);
        chk("stream_miss_cnt", miss_cnt, 0);
      end
      if (i == 12) chk("flush_miss_cnt", miss_cnt, 1);
    end
    chk("table_resolve_cnt", resolve_cnt, 12);
    chk("table_miss_cnt", miss_cnt, 2);

    // Random traffic against the model, with a reset in the middle of it.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      apply(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)), rdy);
    end

    // Saturation on the narrow-counter instance: push 1 then resolve 0, twenty times.
    bus.pred_valid = 0; bus.resolve_valid = 0;
    for (int i = 0; i < 20; i++) begin
      sbus.pred_valid = 1; sbus.pred_bit = 1; sbus.resolve_valid = 0; sbus.resolve_taken = 0;
      @(posedge clk); #1;
      sbus.pred_valid = 0; sbus.resolve_valid = 1;
      @(posedge clk); #1;
      chk("sat_mispredict_pulse", sbus.mispredict, 1);
      if (i == 9) chk("sat_resolve_cnt_mid", s_resolve_cnt, 10);
      if (i == 14) chk("sat_miss_cnt_at_max", s_miss_cnt, 15);
    end
    sbus.resolve_valid = 0;
    @(posedge clk); #1;
    chk("sat_resolve_cnt_held", s_resolve_cnt, 15);
    chk("sat_miss_cnt_held", s_miss_cnt, 15);
    chk("sat_occupancy", s_occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
